// File: rtl/irq_ctrl.sv
// irq_ctrl: NIRQ-source interrupt controller with MASK/PEND/ID/EOI registers and an IDLE/REQ/SERVICE CPU handshake.
// Define IRQ_CTRL_EDGE_EN for rising-edge capture of irq; the default build captures levels.

module irq_ctrl #(
   parameter int unsigned NIRQ = 8
) (
   input  logic            Clk,
   input  logic            Clrn,
   input  logic [NIRQ-1:0] irq,
   output logic            intr,
   input  logic            inta,
   input  logic            we,
   input  logic [1:0]      addr,
   input  logic [31:0]     wdata,
   output logic [31:0]     rdata
);

   localparam int unsigned DATA_W = 32;
   localparam int unsigned ID_W   = 3;
   localparam int unsigned PAD_W  = DATA_W - 1 - ID_W;

   localparam logic [1:0] A_MASK = 2'd0;
   localparam logic [1:0] A_PEND = 2'd1;
   localparam logic [1:0] A_ID   = 2'd2;
   localparam logic [1:0] A_EOI  = 2'd3;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_REQ     = 2'd1,
      ST_SERVICE = 2'd2
   } state_t;

   state_t            r_state;
   logic [NIRQ-1:0]   r_sync1;
   logic [NIRQ-1:0]   r_sync2;
   logic [NIRQ-1:0]   r_mask;
   logic [NIRQ-1:0]   r_pend;
   logic [ID_W-1:0]   r_id;

   logic [NIRQ-1:0]   w_event;
   logic [NIRQ-1:0]   w_active;
   logic [NIRQ-1:0]   w_ack_clr;
   logic [NIRQ-1:0]   w_pend_clr;
   logic [NIRQ-1:0]   w_pend_next;
   logic [ID_W-1:0]   w_win_id;
   logic              w_wr_mask;
   logic              w_wr_pend;
   logic              w_wr_eoi;
   logic              w_ack;
   logic              w_unused;

`ifdef IRQ_CTRL_EDGE_EN
   logic [NIRQ-1:0]   r_sync3;

   // Event on a synchronized 0->1 transition only.
   assign w_event = r_sync2 & ~r_sync3;

   always_ff @(posedge Clk or negedge Clrn) begin
      if (!Clrn) begin
         r_sync3 <= '0;
      end else begin
         r_sync3 <= r_sync2;
      end
   end
`else
   // Level capture: every cycle the synchronized line is high is an event.
   assign w_event = r_sync2;
`endif

   assign w_wr_mask = we && (addr == A_MASK);
   assign w_wr_pend = we && (addr == A_PEND);
   assign w_wr_eoi  = we && (addr == A_EOI);
   assign w_ack     = (r_state == ST_REQ) && inta;
   assign w_unused  = &{1'b0, wdata};

   assign w_active    = r_pend & r_mask;
   assign w_ack_clr   = w_ack ? (NIRQ'(1) << r_id) : '0;
   assign w_pend_clr  = (w_wr_pend ? wdata[NIRQ-1:0] : '0) | w_ack_clr;
   // New events win over W1C and acknowledge clears in the same cycle.
   assign w_pend_next = (r_pend & ~w_pend_clr) | w_event;

   // Lowest-index enabled pending source wins.
   always_comb begin
      w_win_id = '0;
      for (int i = NIRQ - 1; i >= 0; i--) begin
         if (w_active[i]) begin
            w_win_id = ID_W'(i);
         end
      end
   end

   always_comb begin
      rdata = '0;
      case (addr)
         A_MASK:  rdata = DATA_W'(r_mask);
         A_PEND:  rdata = DATA_W'(r_pend);
         A_ID:    rdata = {(r_state == ST_SERVICE), {PAD_W{1'b0}}, r_id};
         default: rdata = '0;
      endcase
   end

   always_ff @(posedge Clk or negedge Clrn) begin
      if (!Clrn) begin
         r_state <= ST_IDLE;
         intr    <= 1'b0;
         r_sync1 <= '0;
         r_sync2 <= '0;
         r_mask  <= '0;
         r_pend  <= '0;
         r_id    <= '0;
      end else begin
         r_sync1 <= irq;
         r_sync2 <= r_sync1;
         r_pend  <= w_pend_next;
         if (w_wr_mask) begin
            r_mask <= wdata[NIRQ-1:0];
         end
         // id is only latched on IDLE->REQ, so it stays frozen through REQ and SERVICE.
         case (r_state)
            ST_IDLE: begin
               if (|w_active) begin
                  r_id    <= w_win_id;
                  r_state <= ST_REQ;
                  intr    <= 1'b1;
               end
            end
            ST_REQ: begin
               if (inta) begin
                  r_state <= ST_SERVICE;
                  intr    <= 1'b0;
               end
            end
            ST_SERVICE: begin
               if (w_wr_eoi) begin
                  r_state <= ST_IDLE;
               end
            end
            default: begin
               r_state <= ST_IDLE;
               intr    <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: doc/irq_ctrl.md
IRQ_CTRL -- requirements
Module: irq_ctrl

Interface
REQ-001 Parameter NIRQ, default 8, number of interrupt source lines (legal 1..8).
REQ-002 Clk  input  1  system clock; all state updates on rising edge.
REQ-003 Clrn  input  1  asynchronous active-low reset.
REQ-004 irq  input  NIRQ  external interrupt source lines, asynchronous to Clk.
REQ-005 intr  output  1  interrupt request to CPU.
REQ-006 inta  input  1  CPU acknowledge, single-cycle pulse sampled on Clk.
REQ-007 we  input  1  register write strobe.
REQ-008 addr  input  2  register select: 0 MASK, 1 PEND, 2 ID, 3 EOI.
REQ-009 wdata  input  32  register write data.
REQ-010 rdata  output  32  register read data, combinational from addr.

Function
REQ-011 irq SHALL pass a 2-flop synchronizer before any use; detected events SHALL appear in PEND 3 cycles after the input change.
REQ-012 PEND bit i SHALL set on a detected event of irq[i]; set SHALL have priority over any clear in the same cycle.
REQ-013 MASK bit i = 1 SHALL enable source i; masked sources SHALL still set PEND.
REQ-014 Write to PEND SHALL clear bits where wdata = 1 (write-1-to-clear); bits above NIRQ SHALL be ignored.
REQ-015 Write to MASK SHALL load wdata[NIRQ-1:0]; reads of MASK/PEND SHALL return the register zero-extended.
REQ-016 Read of ID SHALL return {insvc, 28'b0, id[2:0]}, where insvc is 1 in SERVICE state (bit 31); reads of EOI SHALL return 0.
REQ-017 Priority: the lowest-index bit of (PEND & MASK) SHALL win.
REQ-018 FSM states: IDLE, REQ, SERVICE.
REQ-019 IDLE: if (PEND & MASK) != 0, latch the winning id and go to REQ; intr SHALL rise in the cycle after that.
REQ-020 REQ: intr SHALL be held at 1 and id SHALL be frozen until inta = 1, even if the source is later masked or cleared.
REQ-021 REQ with inta = 1: clear PEND[id], go to SERVICE; intr SHALL be 0 from the next cycle.
REQ-022 SERVICE: intr = 0; new events SHALL only accumulate in PEND (no nesting).
REQ-023 Any write to EOI in SERVICE SHALL return to IDLE; re-arbitration SHALL occur on the following cycle.
REQ-024 EOI writes in IDLE or REQ, and inta in IDLE or SERVICE, SHALL be ignored.
REQ-025 intr SHALL be a registered output (no combinational path from irq or inta).

Reset
REQ-026 Clrn = 0 SHALL immediately force: state IDLE, intr 0, MASK 0, PEND 0, id 0, synchronizer/edge flops 0.
REQ-027 Reset asserted in REQ or SERVICE SHALL abandon the request with no acknowledge required.
REQ-028 After reset release, rdata SHALL read 0 at every address.

Configuration
REQ-029 Macro IRQ_CTRL_EDGE_EN defined: PEND[i] SHALL set on a synchronized 0->1 transition of irq[i] only.
REQ-030 IRQ_CTRL_EDGE_EN undefined: PEND[i] SHALL set in every cycle that synchronized irq[i] = 1 (level mode); a W1C clear SHALL be overridden while the level persists.

Verification
REQ-031 MASK=0x01, pulse irq[0] 1 cycle (edge mode) -> PEND=0x01 after 3 cycles, intr=1 next cycle, ID=0x00000000.
REQ-032 MASK=0xFF, irq=0x28 in the same cycle -> id=3; after inta, PEND=0x20, ID=0x80000003; EOI -> intr re-asserts with id=5.
REQ-033 In REQ with id=2, write MASK=0x00 -> intr stays 1 until inta; inta -> SERVICE, PEND[2]=0.
REQ-034 In SERVICE, irq[1] pulses -> intr stays 0, PEND[1]=1; EOI write -> intr=1 two cycles later, id=1.
REQ-035 Assert Clrn=0 during REQ -> intr=0 and rdata=0 immediately at all addresses; no intr after release until a new event.
REQ-036 W1C on PEND[4] in the same cycle as a new irq[4] event -> PEND[4] remains 1.
